// File: rtl/escalonador_animacao.sv
// Animation scheduler: picks the current (state, frame) image and streams its 1024 bytes
// from image memory to the display driver, one byte per valid/ready handshake.
module escalonador_animacao #(
    parameter int QUADROS_MAX      = 4,
    parameter int TICKS_POR_QUADRO = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] estado,
    input  logic       tick_quadro,
    output logic       mem_rd,
    output logic [3:0] estado_img,
    output logic [2:0] quadro_img,
    output logic [9:0] end_byte,
    input  logic [7:0] mem_dado,
    output logic [7:0] saida_dado,
    output logic       saida_valido,
    input  logic       saida_pronto,
    output logic       quadro_fim,
    output logic       ocupado
);

    localparam int             TW         = (TICKS_POR_QUADRO > 1) ? $clog2(TICKS_POR_QUADRO) : 1;
    localparam logic [TW-1:0]  TICK_ULT   = TW'(TICKS_POR_QUADRO - 1);
    localparam logic [2:0]     QUADRO_ULT = 3'(QUADROS_MAX - 1);
    localparam logic [9:0]     BYTE_ULT   = 10'd1023;

    typedef enum logic [1:0] {OCIOSO, LENDO, ENVIANDO, FIM} fsm_t;

    fsm_t          fsm_q, fsm_d;
    logic [3:0]    estado_reg;
    logic [2:0]    quadro_cnt;
    logic [TW-1:0] tick_cnt;
    logic          pendente;
    logic          estado_ok;
    logic          estado_novo;
    logic          tick_fim;

    always_comb begin
        estado_ok = 1'b0;
        case (estado)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: estado_ok = 1'b1;
            default:                                      estado_ok = 1'b0;
        endcase
    end

    assign estado_novo = estado_ok && (estado != estado_reg);
    assign tick_fim    = tick_quadro && (tick_cnt == TICK_ULT);

    // A state change restarts the animation and wins over a tick in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_reg <= 4'b0000;
            quadro_cnt <= 3'd0;
            tick_cnt   <= '0;
        end else if (estado_novo) begin
            estado_reg <= estado;
            quadro_cnt <= 3'd0;
            tick_cnt   <= '0;
        end else if (tick_quadro) begin
            if (tick_fim) begin
                tick_cnt   <= '0;
                quadro_cnt <= (quadro_cnt == QUADRO_ULT) ? 3'd0 : quadro_cnt + 3'd1;
            end else begin
                tick_cnt <= tick_cnt + TW'(1);
            end
        end
    end

    // Set beats clear so an event arriving while OCIOSO takes a request is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pendente <= 1'b1;
        end else if (estado_novo || tick_fim) begin
            pendente <= 1'b1;
        end else if (fsm_q == OCIOSO) begin
            pendente <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm_q <= OCIOSO;
        end else begin
            fsm_q <= fsm_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            OCIOSO:   if (pendente) fsm_d = LENDO;
            LENDO:    fsm_d = ENVIANDO;
            ENVIANDO: if (saida_pronto) fsm_d = (end_byte == BYTE_ULT) ? FIM : LENDO;
            FIM:      fsm_d = OCIOSO;
            default:  fsm_d = OCIOSO;
        endcase
    end

    // Image selection is latched only at transfer start so a frame is never mixed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_img   <= 4'b0000;
            quadro_img   <= 3'd0;
            end_byte     <= 10'd0;
            saida_dado   <= 8'd0;
            saida_valido <= 1'b0;
        end else begin
            case (fsm_q)
                OCIOSO: begin
                    if (pendente) begin
                        estado_img <= estado_reg;
                        quadro_img <= quadro_cnt;
                        end_byte   <= 10'd0;
                    end
                end
                LENDO: begin
                    saida_dado   <= mem_dado;
                    saida_valido <= 1'b1;
                end
                ENVIANDO: begin
                    if (saida_pronto) begin
                        saida_valido <= 1'b0;
                        if (end_byte != BYTE_ULT) end_byte <= end_byte + 10'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_rd     = (fsm_q == LENDO);
    assign quadro_fim = (fsm_q == FIM);
    assign ocupado    = (fsm_q != OCIOSO);

endmodule

// File: tb/tb_escalonador_animacao.sv
// Bench for escalonador_animacao: a reference model predicts which (state, frame) images get
// sent; a monitor checks every memory read and every byte handed to the display driver.
module tb_escalonador_animacao;

    localparam int Q = 4;
    localparam int T = 8;
    localparam int W = 7;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] estado;
    logic       tick_quadro;
    logic       mem_rd;
    logic [3:0] estado_img;
    logic [2:0] quadro_img;
    logic [9:0] end_byte;
    logic [7:0] mem_dado;
    logic [7:0] saida_dado;
    logic       saida_valido;
    logic       saida_pronto;
    logic       quadro_fim;
    logic       ocupado;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];

    // reference model state
    logic [3:0] m_estado;
    int         m_frame, m_ticks;
    bit         m_pend, x_active, x_send, x_fim;
    int         x_bytes;

    // monitor state
    bit           mon_in;
    int           mon_byte, mon_xfers;
    logic [W-1:0] mon_desc;
    bit           rand_pronto;

    escalonador_animacao #(.QUADROS_MAX(Q), .TICKS_POR_QUADRO(T)) dut (
        .clk(clk), .rst_n(rst_n), .estado(estado), .tick_quadro(tick_quadro),
        .mem_rd(mem_rd), .estado_img(estado_img), .quadro_img(quadro_img),
        .end_byte(end_byte), .mem_dado(mem_dado), .saida_dado(saida_dado),
        .saida_valido(saida_valido), .saida_pronto(saida_pronto),
        .quadro_fim(quadro_fim), .ocupado(ocupado)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] img_byte(input logic [3:0] e, input logic [2:0] q,
                                            input logic [9:0] a);
        logic [7:0] t;
        t = a[7:0] ^ {a[9:8], 6'd0};
        return t + {e, 1'b0, q};
    endfunction

    // image memory answers only while it is being read
    assign mem_dado = mem_rd ? img_byte(estado_img, quadro_img, end_byte) : 8'hA5;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit code_ok(input logic [3:0] e);
        return e inside {4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    endfunction

    task automatic model_reset();
        m_estado = 4'b0000; m_frame = 0; m_ticks = 0; m_pend = 1'b1;
        x_active = 1'b0; x_send = 1'b0; x_fim = 1'b0; x_bytes = 0;
        exp_q.delete();
        mon_in = 1'b0; mon_byte = 0;
    endtask

    function automatic bit model_idle();
        return !x_active && !x_fim && !m_pend;
    endfunction

    // One clock of the model: a frame is 1024 read+handshake pairs followed by a done cycle;
    // a request seen while idle starts the next frame from the model's current state/frame.
    always @(posedge clk) begin
        if (rst_n) begin
            if (!x_active && !x_fim) begin
                if (m_pend) begin
                    exp_q.push_back({m_estado, 3'(m_frame)});
                    x_active = 1'b1; x_send = 1'b0; x_bytes = 0; m_pend = 1'b0;
                end
            end else if (x_fim) begin
                x_fim = 1'b0;
            end else if (!x_send) begin
                x_send = 1'b1;
            end else if (saida_pronto) begin
                x_send = 1'b0;
                x_bytes++;
                if (x_bytes == 1024) begin
                    x_active = 1'b0; x_fim = 1'b1;
                end
            end
            if (code_ok(estado) && estado != m_estado) begin
                m_estado = estado; m_frame = 0; m_ticks = 0; m_pend = 1'b1;
            end else if (tick_quadro) begin
                if (m_ticks == T - 1) begin
                    m_ticks = 0; m_frame = (m_frame + 1) % Q; m_pend = 1'b1;
                end else begin
                    m_ticks++;
                end
            end
        end
    end

    // Monitor: pops one expected image per transfer and checks address and data of each byte.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_rd) begin
                if (!mon_in) begin
                    mon_xfers++; mon_in = 1'b1; mon_byte = 0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_xfer", 32'd1, 32'd0);
                        mon_desc = '1;
                    end else begin
                        mon_desc = exp_q.pop_front();
                    end
                end
                chk("estado_img", 32'(estado_img), 32'(mon_desc[6:3]));
                chk("quadro_img", 32'(quadro_img), 32'(mon_desc[2:0]));
                chk("end_byte", 32'(end_byte), 32'(mon_byte));
            end
            if (saida_valido && saida_pronto) begin
                chk("saida_dado", 32'(saida_dado),
                    32'(img_byte(mon_desc[6:3], mon_desc[2:0], 10'(mon_byte))));
                mon_byte++;
            end
            if (quadro_fim) begin
                chk("fim_in_xfer", 32'(mon_in), 32'd1);
                chk("fim_bytes", 32'(mon_byte), 32'd1024);
                mon_in = 1'b0;
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_pronto) saida_pronto = ($urandom_range(0, 9) < 7);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_estado(input logic [3:0] v);
        estado = v;
        step();
    endtask

    task automatic pulse_ticks(input int n);
        repeat (n) begin
            tick_quadro = 1'b1; step();
            tick_quadro = 1'b0; step();
        end
    endtask

    task automatic wait_idle(input string nm, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (model_idle()) return;
            step();
        end
        chk({nm, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic wait_byte_read(input logic [9:0] a, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mem_rd && end_byte == a) return;
            step();
        end
        chk("wait_byte_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_mem_rd"}, 32'(mem_rd), 32'd0);
        chk({nm, "_estado_img"}, 32'(estado_img), 32'd0);
        chk({nm, "_quadro_img"}, 32'(quadro_img), 32'd0);
        chk({nm, "_end_byte"}, 32'(end_byte), 32'd0);
        chk({nm, "_saida_dado"}, 32'(saida_dado), 32'd0);
        chk({nm, "_saida_valido"}, 32'(saida_valido), 32'd0);
        chk({nm, "_quadro_fim"}, 32'(quadro_fim), 32'd0);
        chk({nm, "_ocupado"}, 32'(ocupado), 32'd0);
    endtask

    initial begin
        logic [7:0] held;
        rst_n = 1'b0; estado = 4'b0000; tick_quadro = 1'b0; saida_pronto = 1'b1;
        rand_pronto = 1'b0; mon_xfers = 0; mon_desc = '0;
        model_reset();
        repeat (3) step();
        chk_reset_outputs("rst");
        rst_n = 1'b1;

        // frame 0 of IDLE streams right after reset
        step();
        wait_idle("boot", 4000);
        step();

        // state change while idle: read strobe exactly two edges later
        estado = 4'b0010;
        step();
        chk("lat_edge_k", 32'(mem_rd), 32'd0);
        step();
        chk("lat_edge_k1", 32'(mem_rd), 32'd1);
        wait_idle("lat", 4000);

        // 32 ticks: frames 1,2,3,0 each sent once
        for (int r = 0; r < 4; r++) begin
            pulse_ticks(T);
            wait_idle("ticks", 4000);
        end

        // stall the display on byte 10
        set_estado(4'b0001);
        wait_byte_read(10'd10, 200);
        saida_pronto = 1'b0;
        step();
        held = img_byte(4'b0001, 3'd0, 10'd10);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valido", 32'(saida_valido), 32'd1);
            chk("stall_dado", 32'(saida_dado), 32'(held));
            chk("stall_end_byte", 32'(end_byte), 32'd10);
            chk("stall_mem_rd", 32'(mem_rd), 32'd0);
            if (i == 4) saida_pronto = 1'b1;
            step();
        end
        wait_idle("stall", 4000);

        // events during a transfer coalesce into one follow-up; 0011 ignored
        rand_pronto = 1'b1;
        mon_xfers = 0;
        set_estado(4'b0100);
        repeat (100) step();
        pulse_ticks(T);
        set_estado(4'b1000);
        set_estado(4'b0011);
        repeat (5) step();
        wait_idle("coalesce", 12000);
        step();
        chk("coalesce_xfers", 32'(mon_xfers), 32'd2);

        // random state codes, ticks and display back-pressure
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 199) == 0) estado = 4'($urandom_range(0, 15));
            tick_quadro = ($urandom_range(0, 39) == 0);
            step();
        end
        tick_quadro = 1'b0;
        rand_pronto = 1'b0;
        saida_pronto = 1'b1;
        step();
        wait_idle("random", 20000);

        // reset in the middle of a transfer aborts it
        set_estado(4'b0000);
        wait_idle("pre_abort", 4000);
        pulse_ticks(T);
        wait_byte_read(10'd500, 2000);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outputs("abort");
        repeat (3) step();
        chk("abort_quadro_fim", 32'(quadro_fim), 32'd0);
        rst_n = 1'b1;
        step();
        wait_idle("after_abort", 4000);
        step();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
